// File: rtl/servo_ramp_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// servo_ramp_controller: bus-programmed, rate-limited four-channel servo sequencer.
// Build option SERVO_RAMP_IRQ_EN adds the settle interrupt.   Rev 1.0
// ---------------------------------------------------------------------------
module servo_ramp_controller #(
    parameter int unsigned FRAME_CYCLES = 240000,
    parameter int unsigned MIN_PULSE    = 12000,
    parameter int unsigned MAX_PULSE    = 24000
) (
    input  logic        raw_clk,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic [15:0] data_in,
    input  logic        write_strobe,
    output logic [15:0] data_out,
    output logic [15:0] servo_value_0,
    output logic [15:0] servo_value_1,
    output logic [15:0] servo_value_2,
    output logic [15:0] servo_value_3,
    output logic        busy,
    output logic        irq
);
    localparam int unsigned      CNT_W      = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [15:0]      MIN_VAL    = 16'(MIN_PULSE);
    localparam logic [15:0]      MAX_VAL    = 16'(MAX_PULSE);
    localparam logic [15:0]      MID_VAL    = 16'((MIN_PULSE + MAX_PULSE) / 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [1:0]       ch;
    logic [CNT_W-1:0] frame_count;
    logic             tick;
    logic [15:0]      target  [4];
    logic [15:0]      current [4];
    logic [15:0]      step    [4];
    logic [3:0]       at_target;
    logic [15:0]      write_target;
    logic [16:0]      diff;
    logic [16:0]      abs_diff;
    logic [15:0]      next_current;
    logic [15:0]      read_data;
    logic             irq_pending;

    assign tick = (frame_count == LAST_COUNT);

    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= '0;
        end else if (tick) begin
            frame_count <= '0;
        end else begin
            frame_count <= frame_count + CNT_W'(1);
        end
    end

    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ch    <= 2'd0;
        end else begin
            state <= state_next;
            ch    <= (state == UPDATE) ? ch + 2'd1 : 2'd0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tick) state_next = UPDATE;
            UPDATE:  if (ch == 2'd3) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_comb begin
        write_target = data_in;
        if (data_in < MIN_VAL) begin
            write_target = MIN_VAL;
        end else if (data_in > MAX_VAL) begin
            write_target = MAX_VAL;
        end
    end

    // Moving toward an in-range target by less than the gap keeps current in range.
    always_comb begin
        diff     = {1'b0, target[ch]} - {1'b0, current[ch]};
        abs_diff = diff[16] ? (17'd0 - diff) : diff;
        if ((step[ch] == 16'd0) || (abs_diff <= {1'b0, step[ch]})) begin
            next_current = target[ch];
        end else if (!diff[16]) begin
            next_current = current[ch] + step[ch];
        end else begin
            next_current = current[ch] - step[ch];
        end
    end

    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                target[i]  <= MID_VAL;
                current[i] <= MID_VAL;
                step[i]    <= 16'd0;
            end
        end else begin
            if (write_strobe && (address[3:2] == 2'b00)) begin
                target[address[1:0]] <= write_target;
            end
            if (write_strobe && (address[3:2] == 2'b01)) begin
                step[address[1:0]] <= data_in;
            end
            if (state == UPDATE) begin
                current[ch] <= next_current;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_at_target
        assign at_target[g] = (current[g] == target[g]);
    end

`ifdef SERVO_RAMP_IRQ_EN
    logic was_unsettled;

    // A settle event that coincides with a clear keeps the interrupt asserted.
    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_pending   <= 1'b0;
            was_unsettled <= 1'b0;
        end else begin
            if ((state == UPDATE) && (ch == 2'd0)) begin
                was_unsettled <= ~&at_target;
            end
            if ((state == DONE) && (&at_target) && was_unsettled) begin
                irq_pending <= 1'b1;
            end else if (write_strobe && (address == 4'd8) && data_in[8]) begin
                irq_pending <= 1'b0;
            end
        end
    end
`else
    assign irq_pending = 1'b0;
`endif

    assign irq = irq_pending;

    always_comb begin
        read_data = 16'd0;
        if (address[3:2] == 2'b00) begin
            read_data = current[address[1:0]];
        end else if (address[3:2] == 2'b01) begin
            read_data = step[address[1:0]];
        end else if (address == 4'd8) begin
            read_data = {7'd0, irq_pending, at_target, 3'd0, busy};
        end
    end

    always_ff @(posedge raw_clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= 16'd0;
        end else begin
            data_out <= read_data;
        end
    end

    assign servo_value_0 = current[0];
    assign servo_value_1 = current[1];
    assign servo_value_2 = current[2];
    assign servo_value_3 = current[3];

endmodule
`default_nettype wire

// File: doc/servo_ramp_controller.md
# servo_ramp_controller

Memory-mapped sequencer that sits between the CPU peripheral bus and the four-channel servo pulse generator. Software writes a target pulse width and a slew step per channel. Once per servo frame, an internal scheduler walks the four channels and moves each `servo_value_n` toward its target by at most its step. This gives rate-limited servo motion without CPU involvement, plus a status word and an optional "all channels settled" interrupt.

## Interface
- `FRAME_CYCLES`, 240000: clocks per servo frame (20 ms at 12 MHz).
- `MIN_PULSE`, 12000: lowest legal pulse count (1 ms).
- `MAX_PULSE`, 24000: highest legal pulse count (2 ms).
- `raw_clk`  in  1  system clock, all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  4  register select.
- `data_in`  in  16  write data.
- `write_strobe`  in  1  one-cycle write enable.
- `data_out`  out  16  registered read data for `address`.
- `servo_value_0`..`servo_value_3`  out  16 each  current commanded pulse count to the pulse generator.
- `busy`  out  1  high while a frame update is in progress.
- `irq`  out  1  settle interrupt, level, sticky until cleared.

## Operation
- Register map:
  - 0–3: write sets target_n; read returns current value n.
  - 4–7: step_n, read/write. Step 0 means jump straight to target.
  - 8: status. Read returns bit0 = busy, bits7:4 = at_target[3:0], bit8 = irq pending. Writing with bit8 = 1 clears irq.
  - Addresses 9–15: reads return 0, writes are ignored.
- Target writes are clamped to [MIN_PULSE, MAX_PULSE] when stored.
- Reset values:
  - target_n and current_n = (MIN_PULSE+MAX_PULSE)/2 = 18000.
  - step_n = 0.
  - busy = 0, irq = 0, data_out = 0.
  - Frame counter = 0, FSM in IDLE.
- Frame counter counts 0..FRAME_CYCLES-1 and wraps. It raises `tick` for the single cycle where count == FRAME_CYCLES-1.
- FSM states:
  - IDLE: on tick, go to UPDATE with ch = 0.
  - UPDATE: process channel ch. If ch == 3, go to DONE; otherwise ch+1.
  - DONE: evaluate settle, then go to IDLE.
- Per-channel update uses 17-bit signed diff = target − current:
  - If step == 0 or |diff| ≤ step: current ← target.
  - Else current ← current + step (diff > 0) or current − step (diff < 0).
  - The result never leaves [MIN_PULSE, MAX_PULSE].
- at_target_n = (current_n == target_n), evaluated combinationally.
- Settle: in DONE, if all four at_target bits are set and at least one was clear at the start of this frame's UPDATE, set irq.
- Simultaneous events:
  - A target_k write in the same cycle UPDATE processes channel k: the update uses the old target, and the new target is stored and applied next frame.
  - A step write follows the same rule.
  - An irq-clear write in the same cycle DONE sets irq: set wins.
  - A tick while not IDLE cannot occur, because the update takes 6 cycles and FRAME_CYCLES ≥ 8 is required.
- Reset mid-update aborts the update. All state returns to reset values, and no partial channel write survives.

## Timing
- Tick occurs at cycle FRAME_CYCLES-1 after reset release, then every FRAME_CYCLES cycles.
- servo_value_k updates at the clock edge k+2 cycles after the tick edge (IDLE→UPDATE takes 1, plus k).
- busy is high from the edge after tick through the DONE cycle, 5 cycles total.
- irq rises at the edge ending DONE, 6 cycles after tick.
- data_out has 1-cycle read latency: it reflects `address` sampled on the previous edge.
- Register writes take effect on the edge where write_strobe is high.

## Configuration
- `SERVO_RAMP_IRQ_EN`:
  - Defined: settle detection, status bit8 and the `irq` port are active as described.
  - Undefined: settle logic is not built, `irq` is tied 0, status bit8 reads 0, and writes to bit8 are ignored.

## Test plan
- Reset: release reset_n, read addresses 0–3 → 18000 each; busy = 0; irq = 0; status = 0x00F0.
- Step 0 jump (FRAME_CYCLES = 16): write target_0 = 20000 → servo_value_0 = 20000 two cycles after the first tick; other channels stay 18000.
- Ramp: step_1 = 1000, target_1 = 15500 → successive frames give 17000, 16000, 15500, then hold; irq rises after the 15500 frame (IRQ_EN defined).
- Clamp: write target_2 = 30000 then 100 → stored target reads back via ramp as 24000 then 12000; servo_value_2 never leaves [12000, 24000].
- Collision: write target_3 = 22000 in the UPDATE cycle for channel 3 → no change that frame; 22000 appears next frame (step 0).
- Reset mid-update: assert reset_n low during UPDATE ch = 1 → all outputs return to reset values; the next tick comes FRAME_CYCLES-1 cycles after release.
